// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: per-register outstanding-write counters that gate issue in decode.
// Optional macro SCOREBOARD_WB_BYPASS_EN lets a same-cycle final writeback release dependants.
module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        Iss_En,
    input  logic [4:0]  Iss_Rd,
    input  logic [4:0]  Iss_Rs,
    input  logic [4:0]  Iss_Rt,
    input  logic        Use_Rs,
    input  logic        Use_Rt,
    input  logic        Wb_En,
    input  logic [4:0]  Wb_Rd,
    output logic        Stall,
    output logic [31:0] Busy,
    output logic        Err
);

    localparam logic [CNT_W-1:0] MAX = '1;

    // Entry 0 is never written with anything but zero, so r0 reads as idle everywhere.
    logic [CNT_W-1:0] cnt     [32];
    logic [CNT_W-1:0] cnt_nxt [32];

    logic pend_rs, pend_rt, full_rd;
    logic haz_rs, haz_rt, sat, acc, err_set;

    always_comb begin
        pend_rs = (cnt[Iss_Rs] != '0);
        pend_rt = (cnt[Iss_Rt] != '0);
        full_rd = (cnt[Iss_Rd] == MAX);
`ifdef SCOREBOARD_WB_BYPASS_EN
        if (Wb_En && (Wb_Rd == Iss_Rs) && (cnt[Iss_Rs] == CNT_W'(1))) pend_rs = 1'b0;
        if (Wb_En && (Wb_Rd == Iss_Rt) && (cnt[Iss_Rt] == CNT_W'(1))) pend_rt = 1'b0;
        if (Wb_En && (Wb_Rd == Iss_Rd)) full_rd = 1'b0;
`endif
    end

    assign haz_rs = Use_Rs && (Iss_Rs != 5'd0) && pend_rs;
    assign haz_rt = Use_Rt && (Iss_Rt != 5'd0) && pend_rt;
    assign sat    = (Iss_Rd != 5'd0) && full_rd;
    assign Stall  = Clr || (Iss_En && (haz_rs || haz_rt || sat));
    assign acc    = Iss_En && !Stall;

    // Simultaneous issue and retire on one register cancel out.
    always_comb begin
        cnt_nxt[0] = '0;
        for (int r = 1; r < 32; r++) begin
            cnt_nxt[r] = cnt[r];
            unique case ({acc && (Iss_Rd == 5'(r)),
                          Wb_En && (Wb_Rd == 5'(r)) && (cnt[r] != '0)})
                2'b10:   cnt_nxt[r] = cnt[r] + 1'b1;
                2'b01:   cnt_nxt[r] = cnt[r] - 1'b1;
                default: cnt_nxt[r] = cnt[r];
            endcase
        end
        err_set = Wb_En && (Wb_Rd != 5'd0) && (cnt[Wb_Rd] == '0);
    end

    always_ff @(posedge Clk) begin
        if (Clr) begin
            for (int r = 0; r < 32; r++) cnt[r] <= '0;
            Busy <= '0;
            Err  <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                cnt[r]  <= cnt_nxt[r];
                Busy[r] <= (cnt_nxt[r] != '0);
            end
            if (err_set) Err <= 1'b1;
        end
    end

endmodule
